writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued writeback entries (power of two, min 2).
REQ-002 SHALL have parameter LINK_OFFSET, default 4, byte offset added to PC to form the jal link value.
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset; 0 resets all state immediately, independent of clk.
REQ-005 flush  in  1  synchronous discard of all queued entries.
REQ-006 in_valid  in  1  producer offers a writeback entry.
REQ-007 in_ready  out  1  unit accepts the entry this cycle.
REQ-008 in_rd  in  5  destination register (ignored when in_jal=1).
REQ-009 in_data  in  32  result value (ignored when in_jal=1).
REQ-010 in_jal  in  1  entry is a jal link write.
REQ-011 in_pc  in  32  PC of the jal instruction.
REQ-012 wr_stall  in  1  register bank cannot take a write this cycle.
REQ-013 write  out  1  register-bank write enable.
REQ-014 rd  out  5  register-bank write address.
REQ-015 data  out  32  register-bank write data.
REQ-016 q_rs, q_rt  in  5 each  hazard-query register numbers.
REQ-017 fwd_rs_hit, fwd_rt_hit  out  1 each  query register has a pending write.
REQ-018 fwd_rs_data, fwd_rt_data  out  32 each  youngest pending value for the query register.
REQ-019 pend_mask  out  32  bit i set when register i has at least one queued write.

Function
REQ-020 Handshake: transfer occurs on posedge when in_valid=1 and in_ready=1; in_ready = (count < DEPTH) and flush=0, independent of wr_stall and in_valid.
REQ-021 Entry target SHALL be 31 when in_jal=1, else in_rd; value SHALL be in_pc + LINK_OFFSET (32-bit, wrap modulo 2^32) when in_jal=1, else in_data.
REQ-022 An accepted entry with target 0 SHALL complete the handshake but SHALL NOT be enqueued.
REQ-023 Queue is FIFO of {target, value}; count 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-024 write = (count != 0) and wr_stall=0 and flush=0; rd/data = head entry; head pops on the same posedge.
REQ-025 Latency: entry accepted at edge N into empty queue drives write=1 in the cycle after edge N; bank commits at edge N+1.
REQ-026 rd and data SHALL hold 0 when write=0.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; order preserved.
REQ-028 Full: count=DEPTH forces in_ready=0 even if a pop occurs that cycle (no pass-through).
REQ-029 wr_stall=1 SHALL hold queue contents and head; write=0.
REQ-030 flush=1 at an edge SHALL set count=0 and both pointers to 0; no push, no pop, write=0 and in_ready=0 during that cycle.
REQ-031 Forwarding: fwd_x_hit=1 when any queued entry targets q_x; fwd_x_data = value of youngest such entry; else hit=0, data=0.
REQ-032 Query of register 0 SHALL return hit=0, data=0; pend_mask[0] SHALL always be 0.
REQ-033 Forwarding and pend_mask SHALL reflect queue contents only (not the in_* entry being offered).

Reset
REQ-034 While reset=0: count=0, pointers=0, write=0, rd=0, data=0, in_ready=0, pend_mask=0, all fwd outputs 0.
REQ-035 in_ready SHALL be 1 in the first cycle after reset deasserts (flush=0).
REQ-036 Reset asserted mid-operation SHALL discard all queued entries; no write issued for them.

Structure
REQ-037 Shared package SHALL hold constants REG_LINK=31, REG_ZERO=0, REG_W=5, DATA_W=32 and the entry struct {target, value}.
REQ-038 Queue storage and pointers SHALL be a sub-module wb_fifo; forwarding and pend_mask logic reside in writeback_unit.

Verification
REQ-039 Push rd=5,data=0xDEADBEEF into empty queue -> next cycle write=1, rd=5, data=0xDEADBEEF; pend_mask=0x20 until popped.
REQ-040 Push jal, in_pc=0x00400010 -> write rd=31, data=0x00400014; in_pc=0xFFFFFFFE -> data=0x00000002.
REQ-041 wr_stall=1, push 4 entries -> in_ready=0 on 5th offer; release stall -> 4 writes in push order on 4 consecutive cycles.
REQ-042 Queue r7=1 then r7=2 under stall, q_rs=7 -> fwd_rs_hit=1, fwd_rs_data=2; q_rt=0 -> hit=0, data=0.
REQ-043 Push rd=0,data=0x1234 -> handshake completes, no write, pend_mask=0.
REQ-044 Queue 3 entries, pulse flush (then separately reset=0 mid-drain) -> no further writes, count=0, in_ready=1 next cycle after release.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared constants and entry type for the writeback unit.
package writeback_unit_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_LINK = 5'd31;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One queued register-bank write.
  typedef struct packed {
    logic [REG_W-1:0]  target;
    logic [DATA_W-1:0] value;
  } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Producer handshake plus register-bank write port of the writeback unit.
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rd;
  logic [DATA_W-1:0] in_data;
  logic              in_jal;
  logic [DATA_W-1:0] in_pc;
  logic              wr_stall;
  logic              write;
  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] data;

  // Producer / register-bank side.
  modport master (
    output in_valid, in_rd, in_data, in_jal, in_pc, wr_stall,
    input  in_ready, write, rd, data
  );

  // Writeback unit side.
  modport slave (
    input  in_valid, in_rd, in_data, in_jal, in_pc, wr_stall,
    output in_ready, write, rd, data
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of writeback entries; exposes every slot so the owner can
// scan the live entries for forwarding.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [CNT_W-1:0]       count,
  output logic [PTR_W-1:0]       rd_ptr,
  output wb_entry_t [DEPTH-1:0]  slots
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;

  // Write the pushed entry into the slot at the write pointer.
  // NOTE: the storage array has no reset; a slot is only observed while it
  // lies inside [rd_ptr, rd_ptr+count), so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping; flush and reset both empty the queue.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign slots = mem;

endmodule

// File: rtl/writeback_unit.sv
// Writeback queue in front of the register bank with hazard forwarding of
// the youngest pending value and a pending-register mask.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int LINK_OFFSET = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  writeback_unit_if.slave   wb,
  input  logic [REG_W-1:0]  q_rs,
  input  logic [REG_W-1:0]  q_rt,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data,
  output logic [31:0]       pend_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t             in_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] slots;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  in_ready;
  logic                  push;
  logic                  write_en;

  // Form the queued entry: jal writes the link value to the link register.
  // NOTE: every output of a combinational block is assigned on every path
  // (directly or via a default first) so no latch is inferred.
  always_comb begin
    in_entry.target = wb.in_jal ? REG_LINK : wb.in_rd;
    in_entry.value  = wb.in_jal ? (wb.in_pc + DATA_W'(LINK_OFFSET)) : wb.in_data;
  end

  // Full queue refuses new entries even when the head drains this cycle.
  assign in_ready = reset && !flush && (count < CNT_W'(DEPTH));
  // Writes to register 0 complete the handshake but are dropped.
  assign push     = wb.in_valid && in_ready && (in_entry.target != REG_ZERO);
  assign write_en = reset && (count != '0) && !wb.wr_stall && !flush;

  assign wb.in_ready = in_ready;
  assign wb.write    = write_en;
  assign wb.rd       = write_en ? head.target : '0;
  assign wb.data     = write_en ? head.value  : '0;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_entry (in_entry),
    .pop        (write_en),
    .head       (head),
    .count      (count),
    .rd_ptr     (rd_ptr),
    .slots      (slots)
  );

  // Scan live entries oldest to youngest so the youngest match wins.
  always_comb begin
    wb_entry_t        slot;
    logic [PTR_W-1:0] idx;
    slot        = '0;
    idx         = '0;
    fwd_rs_hit  = 1'b0;
    fwd_rt_hit  = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_data = '0;
    pend_mask   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) begin
        idx  = rd_ptr + PTR_W'(k);
        slot = slots[idx];
        pend_mask[slot.target] = 1'b1;
        if ((q_rs != REG_ZERO) && (slot.target == q_rs)) begin
          fwd_rs_hit  = 1'b1;
          fwd_rs_data = slot.value;
        end
        if ((q_rt != REG_ZERO) && (slot.target == q_rt)) begin
          fwd_rt_hit  = 1'b1;
          fwd_rt_data = slot.value;
        end
      end
    end
    pend_mask[REG_ZERO] = 1'b0;
  end

endmodule
